rv_inst_assembler: RTL and testbench
====================================

// Module: rv_inst_assembler
// PURPOSE
//  Encoder counterpart of the RV32I instruction Controller/decoder: takes decoded fields
//  (op, rd, rs1, rs2, imm) over valid/ready, packs a legal 32-bit RV32I word and emits
//  sequential instruction-memory writes. Loads test programs into imem; output words
//  decode back to the same control signals in the Controller.
// PARAMETERS
//  DEPTH      64            number of 32-bit imem words; power of two, >=2
//  BASE_ADDR  32'h0000_0000 byte address of first written word
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   synchronous reset, active-low
//  clear      in   1   sync restart: pointer to BASE_ADDR, drop pending word, clear full
//  in_valid   in   1   field bundle valid
//  in_ready   out  1   bundle accepted when in_valid & in_ready
//  in_op      in   3   0 ADD,1 SUB,2 ADDI,3 LW,4 SW,5 LUI,6 AUIPC,7 illegal
//  in_rd      in   5   destination register
//  in_rs1     in   5   source 1
//  in_rs2     in   5   source 2 (ADD/SUB/SW only)
//  in_imm     in   20  I/S: imm[11:0] used, [19:12] ignored; U: all 20 bits = inst[31:12]
//  out_valid  out  1   imem write pending
//  out_ready  in   1   imem write taken when out_valid & out_ready
//  out_inst   out  32  encoded instruction
//  out_addr   out  32  byte address = BASE_ADDR + 4*ptr
//  full       out  1   DEPTH words written; sticky until clear/reset
//  err        out  1   one-cycle pulse: illegal op consumed
// BEHAVIOUR
//  Reset (rst_n=0 at edge): out_valid=0, out_inst=0, out_addr=BASE_ADDR, ptr=0, full=0,
//   err=0, state=EMPTY. Reset mid-transfer discards pending word.
//  FSM: EMPTY -> (accept legal op) HOLD; HOLD -> (out handshake, no new accept) EMPTY;
//   HOLD -> (out handshake & accept legal) HOLD; HOLD -> (out handshake, ptr was DEPTH-1) FULL;
//   FULL -> (clear) EMPTY. Any state -> EMPTY on clear.
//  in_ready = ~clear & ~full & (state==EMPTY | out_ready). Back-to-back throughput
//   one word/cycle; latency accept -> out_valid = 1 cycle.
//  out_inst/out_addr stable while out_valid & ~out_ready. ptr++ only on out handshake;
//   ptr reaching DEPTH sets full, never wraps; after full no more accepts.
//  Simultaneous final out handshake and in_valid: in_ready already 0 only if full; a new
//   word may be accepted in the same cycle as ptr->DEPTH-1 write, but not past DEPTH.
//   Precisely: accept blocked when ptr==DEPTH-1 and state==HOLD (no slot left).
//  Encoding (funct7|rs2|rs1|funct3|rd|opcode):
//   ADD  0000000,rs2,rs1,000,rd,0110011    SUB 0100000,rs2,rs1,000,rd,0110011
//   ADDI imm[11:0],rs1,000,rd,0010011      LW  imm[11:0],rs1,010,rd,0000011
//   SW   imm[11:5],rs2,rs1,010,imm[4:0],0100011
//   LUI  imm[19:0],rd,0110111              AUIPC imm[19:0],rd,0010111
//  Illegal op 7: consumed (in_ready as normal), no write, ptr unchanged, err=1 next cycle.
//  clear & in_valid same cycle: clear wins, bundle not accepted.
// STRUCTURE
//  Shared package rv_pkg: opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI,
//   OP_AUIPC), funct3/funct7 values, in_op enum -- same constants the Controller decodes.
//  One combinational sub-module rv_inst_pack (op+fields -> 32-bit word, illegal flag);
//   top holds FSM, output register, pointer and full flag.
// TESTING
//  1 ADD rd=2,rs1=0,rs2=1, out_ready=1 -> out_inst=0x00100133, out_addr=BASE_ADDR, 1 cyc.
//  2 LW rd=14,rs1=2,imm=8 then SW rs2=14,rs1=2,imm=8 back-to-back -> 0x00812703 @+0,
//    0x00E12423 @+4; ADDI rd=4,rs1=1,imm=10 -> 0x00A08213; LUI rd=0,imm=0x39 -> 0x00039037.
//  3 out_ready=0 for 5 cycles with word pending -> out_inst/out_addr stable, in_ready=0.
//  4 DEPTH=4: stream 6 ops -> 4 writes @0,4,8,12; full=1 after 4th; in_ready=0 after.
//  5 in_op=7 -> err pulse 1 cycle, no out_valid, next legal word keeps same address.
//  6 clear while HOLD (and rst_n=0 mid-stream) -> out_valid=0 next cycle, next write @BASE_ADDR.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and the assembler's operation/state enums.
// The opcode, funct3 and funct7 values match the ones the Controller decodes.
package rv_pkg;

  // Major opcodes in inst[6:0]
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // funct3 values in inst[14:12]
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct7 values in inst[31:25] for R-type
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // Operation selector carried on in_op
  typedef enum logic [2:0] {
    IN_ADD     = 3'd0,
    IN_SUB     = 3'd1,
    IN_ADDI    = 3'd2,
    IN_LW      = 3'd3,
    IN_SW      = 3'd4,
    IN_LUI     = 3'd5,
    IN_AUIPC   = 3'd6,
    IN_ILLEGAL = 3'd7
  } in_op_e;

  // Assembler control states
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } asm_state_e;

endpackage

// File: rtl/rv_inst_pack.sv
// Combinational packer: operation select plus register/immediate fields
// become one 32-bit RV32I word. Unknown operations raise o_illegal.
module rv_inst_pack
  import rv_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [19:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_illegal
);

  // Select the instruction format for the requested operation
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    o_inst    = '0;
    o_illegal = 1'b0;
    case (in_op_e'(i_op))
      IN_ADD:   o_inst = {F7_ADD, i_rs2, i_rs1, F3_ADD, i_rd, OP_R};
      IN_SUB:   o_inst = {F7_SUB, i_rs2, i_rs1, F3_ADD, i_rd, OP_R};
      IN_ADDI:  o_inst = {i_imm[11:0], i_rs1, F3_ADD, i_rd, OP_I};
      IN_LW:    o_inst = {i_imm[11:0], i_rs1, F3_LW, i_rd, OP_LOAD};
      IN_SW:    o_inst = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OP_STORE};
      IN_LUI:   o_inst = {i_imm, i_rd, OP_LUI};
      IN_AUIPC: o_inst = {i_imm, i_rd, OP_AUIPC};
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_inst_assembler.sv
// Instruction assembler: accepts decoded field bundles, packs them into
// RV32I words and streams them out as sequential imem writes starting at
// BASE_ADDR. Stops accepting once DEPTH words have been written.
module rv_inst_assembler
  import rv_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [19:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        full,
  output logic        err
);

  // One extra bit so the pointer can reach DEPTH without wrapping
  localparam int              PTR_W    = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  asm_state_e       r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_out_valid;
  logic [31:0]      r_out_inst;
  logic [31:0]      r_out_addr;
  logic             r_full;
  logic             r_err;

  logic [31:0]      w_packed;
  logic             w_illegal;
  logic             w_accept;
  logic             w_accept_legal;
  logic             w_out_hs;
  logic             w_last_slot;
  logic [PTR_W-1:0] w_ptr_next;
  logic [31:0]      w_addr_next;

  rv_inst_pack u_pack (
    .i_op      (in_op),
    .i_rd      (in_rd),
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .i_imm     (in_imm),
    .o_inst    (w_packed),
    .o_illegal (w_illegal)
  );

  // While holding the word for the last slot there is nowhere to put another
  assign w_last_slot = (r_ptr == LAST_PTR);
  assign in_ready    = ~clear & ~r_full &
                       ((r_state == ST_EMPTY) |
                        ((r_state == ST_HOLD) & out_ready & ~w_last_slot));

  assign w_accept       = in_valid & in_ready;
  assign w_accept_legal = w_accept & ~w_illegal;
  assign w_out_hs       = r_out_valid & out_ready;
  assign w_ptr_next     = r_ptr + {{(PTR_W-1){1'b0}}, w_out_hs};
  assign w_addr_next    = BASE_ADDR + 32'({w_ptr_next, 2'b00});

  // Control FSM with output register, write pointer, full flag and error pulse
  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_addr  <= BASE_ADDR;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_EMPTY;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_addr  <= BASE_ADDR;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err      <= w_accept & w_illegal;
      r_ptr      <= w_ptr_next;
      r_out_addr <= w_addr_next;
      if (w_out_hs && w_last_slot) begin
        r_full <= 1'b1;
      end

      case (r_state)
        ST_EMPTY: begin
          if (w_accept_legal) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_out_inst  <= w_packed;
          end
        end
        ST_HOLD: begin
          if (w_out_hs) begin
            if (w_accept_legal) begin
              r_out_inst <= w_packed;
            end else if (w_last_slot) begin
              r_state     <= ST_FULL;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= ST_EMPTY;
              r_out_valid <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_addr  = r_out_addr;
  assign full      = r_full;
  assign err       = r_err;

endmodule

// File: tb/tb_rv_inst_assembler.sv
// Directed bench for rv_inst_assembler (DEPTH=4, BASE_ADDR=0x100) with a
// scoreboard of expected imem writes and immediate assertions at each check.
module tb_rv_inst_assembler;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, full, err;
  logic [2:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [19:0] in_imm;
  logic [31:0] out_inst, out_addr;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt    = 0;
  bit   last_acc;
  wr_t  sb[$];

  rv_inst_assembler #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Reference encoding written straight from the RV32I field layouts
  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [19:0] imm);
    case (op)
      3'd0:    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd1:    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd2:    return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      3'd3:    return {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd4:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd5:    return {imm, rd, 7'b0110111};
      3'd6:    return {imm, rd, 7'b0010111};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [19:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock: settle, score handshakes seen at the coming edge, advance to negedge
  task automatic cycle();
    wr_t e;
    #1;
    last_acc = 1'b0;
    if (!rst_n || clear) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_write", out_addr, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("sb_inst", out_inst, e.inst);
          check("sb_addr", out_addr, e.addr);
        end
      end
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        if (in_op != 3'd7) begin
          e.inst = enc(in_op, in_rd, in_rs1, in_rs2, in_imm);
          e.addr = BASE + 32'(4 * m_cnt);
          sb.push_back(e);
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle();
    cycle();
    clear = 1'b0;
  endtask

  logic [31:0] hold_inst, hold_addr;
  logic [2:0]  ops [6];
  int          k;

  initial begin
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: single ADD, one-cycle latency
    drive(3'd0, 5'd2, 5'd0, 5'd1, 20'd0);
    cycle();
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_inst", out_inst, 32'h0010_0133);
    check("t1_addr", out_addr, BASE);
    idle();
    cycle();
    check("t1_drained", {31'b0, out_valid}, 32'd0);
    do_clear();

    // 2: back-to-back LW, SW, ADDI, LUI fills all four slots
    drive(3'd3, 5'd14, 5'd2, 5'd0, 20'd8);
    cycle();
    check("t2_lw_inst", out_inst, 32'h0081_2703);
    check("t2_lw_addr", out_addr, BASE);
    drive(3'd4, 5'd0, 5'd2, 5'd14, 20'd8);
    cycle();
    check("t2_sw_inst", out_inst, 32'h00E1_2423);
    check("t2_sw_addr", out_addr, BASE + 32'd4);
    drive(3'd2, 5'd4, 5'd1, 5'd0, 20'd10);
    cycle();
    check("t2_addi_inst", out_inst, 32'h00A0_8213);
    drive(3'd5, 5'd0, 5'd0, 5'd0, 20'h00039);
    cycle();
    check("t2_lui_inst", out_inst, 32'h0003_9037);
    check("t2_lui_addr", out_addr, BASE + 32'd12);
    drive(3'd0, 5'd1, 5'd1, 5'd1, 20'd0);
    cycle();
    #1;
    check("t2_full", {31'b0, full}, 32'd1);
    check("t2_in_ready_full", {31'b0, in_ready}, 32'd0);
    check("t2_valid_after_full", {31'b0, out_valid}, 32'd0);
    do_clear();
    check("t2_clear_full", {31'b0, full}, 32'd0);
    check("t2_clear_addr", out_addr, BASE);

    // 3: back-pressure holds the word and blocks input
    out_ready = 1'b0;
    drive(3'd1, 5'd7, 5'd8, 5'd9, 20'd0);
    cycle();
    hold_inst = out_inst;
    hold_addr = out_addr;
    check("t3_inst", hold_inst, enc(3'd1, 5'd7, 5'd8, 5'd9, 20'd0));
    drive(3'd2, 5'd3, 5'd3, 5'd0, 20'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_in_ready", {31'b0, in_ready}, 32'd0);
      cycle();
      check("t3_stable_inst", out_inst, hold_inst);
      check("t3_stable_addr", out_addr, hold_addr);
      check("t3_stable_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    idle();
    cycle();
    do_clear();

    // 4: stream six ops into four slots; only four are accepted
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2;
    ops[3] = 3'd3; ops[4] = 3'd5; ops[5] = 3'd6;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 6) drive(ops[k], 5'(k + 1), 5'(k + 2), 5'(k + 3), 20'(32'h12345 + k));
      else idle();
      cycle();
      if (last_acc) k++;
    end
    #1;
    check("t4_accepted", 32'(k), 32'd4);
    check("t4_full", {31'b0, full}, 32'd1);
    check("t4_in_ready", {31'b0, in_ready}, 32'd0);
    check("t4_sb_drained", 32'(sb.size()), 32'd0);
    do_clear();

    // 5: illegal op pulses err and does not consume an address
    idle();
    drive(3'd0, 5'd5, 5'd6, 5'd7, 20'd0);
    cycle();
    idle();
    cycle();
    drive(3'd7, 5'd1, 5'd1, 5'd1, 20'd0);
    #1;
    check("t5_in_ready", {31'b0, in_ready}, 32'd1);
    cycle();
    idle();
    check("t5_err_pulse", {31'b0, err}, 32'd1);
    check("t5_no_write", {31'b0, out_valid}, 32'd0);
    cycle();
    check("t5_err_clear", {31'b0, err}, 32'd0);
    drive(3'd6, 5'd9, 5'd0, 5'd0, 20'hABCDE);
    cycle();
    idle();
    check("t5_addr_kept", out_addr, BASE + 32'd4);
    check("t5_auipc_inst", out_inst, 32'hABCD_E497);
    cycle();
    do_clear();

    // 6: clear and reset while a word is pending
    out_ready = 1'b0;
    drive(3'd0, 5'd1, 5'd2, 5'd3, 20'd0);
    cycle();
    clear = 1'b1;
    drive(3'd1, 5'd1, 5'd2, 5'd3, 20'd0);
    #1;
    check("t6_clear_blocks", {31'b0, in_ready}, 32'd0);
    cycle();
    clear = 1'b0;
    idle();
    check("t6_clear_valid", {31'b0, out_valid}, 32'd0);
    check("t6_clear_addr", out_addr, BASE);
    out_ready = 1'b1;
    drive(3'd2, 5'd8, 5'd9, 5'd0, 20'hFFFFF);
    cycle();
    idle();
    check("t6_after_clear_addr", out_addr, BASE);
    check("t6_neg_imm", out_inst, 32'hFFF4_8413);
    cycle();
    out_ready = 1'b0;
    drive(3'd0, 5'd3, 5'd3, 5'd3, 20'd0);
    cycle();
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_inst", out_inst, 32'h0);
    check("t6_rst_addr", out_addr, BASE);
    out_ready = 1'b1;
    drive(3'd3, 5'd10, 5'd11, 5'd0, 20'd4);
    cycle();
    idle();
    check("t6_after_rst_addr", out_addr, BASE);
    cycle();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
